// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   arb_state_t : arbiter FSM states
//   NUM_REQ     : number of requesters
//   IDX_W       : width of an encoded requester index
//   rr_pick     : circular first-set search starting at ptr (pure comb)
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} arb_state_t;

  // Returns the first index i in ptr, ptr+1, ... (mod NUM_REQ) with req[i]=1.
  // Scanning from the farthest offset down lets the nearest hit win.
  // With no request set the result is ptr (callers gate on |req).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/decoder_2_to_4.sv
// 2-to-4 one-hot decoder with enable.
//   i_ena : when low the output is all-zero
//   i_in  : encoded index
//   o_out : one-hot of i_in when enabled
module decoder_2_to_4 (
  input  logic       i_ena,
  input  logic [1:0] i_in,
  output logic [3:0] o_out
);
  always_comb begin
    o_out = '0;
    if (i_ena) o_out[i_in] = 1'b1;
  end
endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with bounded hold time and a
// one-cycle dead gap between owners.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   ena       : global arbitration enable
//   req[3:0]  : level requests, held high while the resource is wanted
//   gnt[3:0]  : one-hot grant, zero when idle or in the gap
//   gnt_idx   : encoded owner, meaningful only while gnt_valid
//   gnt_valid : high exactly when gnt is non-zero
//   preempt   : one-cycle pulse after a grant was force-released
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [3:0]   req,
  output logic [3:0]   gnt,
  output logic [1:0]   gnt_idx,
  output logic         gnt_valid,
  output logic         preempt
);
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

  arb_state_t        r_state, w_next;
  logic [IDX_W-1:0]  r_idx, r_ptr;
  logic [HOLD_W-1:0] r_hold;
  logic              r_preempt;

  logic w_in_grant, w_take, w_abort, w_release, w_limit, w_exit, w_dec_ena;

  assign w_in_grant = (r_state == S_GRANT);
  // IDLE and GAP arbitrate identically.
  assign w_take     = !w_in_grant && ena && (|req);
  // Exit priority: abort, then normal release, then hold limit.
  assign w_abort    = w_in_grant && !ena;
  assign w_release  = w_in_grant && ena && !req[r_idx];
  assign w_limit    = w_in_grant && ena && req[r_idx] && HOLD_EN && (r_hold == HOLD_LAST);
  assign w_exit     = w_abort || w_release || w_limit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE, S_GAP: w_next = w_take ? S_GRANT : S_IDLE;
      S_GRANT:       w_next = w_exit ? S_GAP : S_GRANT;
      default:       w_next = S_IDLE;
    endcase
  end

  // Output logic: everything derives from registered state.
  always_comb begin
    w_dec_ena = w_in_grant;
    gnt_valid = w_in_grant;
  end

  // Owner index, rotation pointer, hold counter and preempt pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= w_limit;
      if (w_take) begin
        r_idx  <= rr_pick(req, r_ptr);
        r_hold <= '0;
      end else if (w_in_grant && !w_exit && HOLD_EN && (r_hold != HOLD_LAST)) begin
        r_hold <= r_hold + 1'b1;
      end
      // Abort leaves the pointer alone so the same owner is favoured again.
      if (w_release || w_limit) r_ptr <= r_idx + 1'b1;
    end
  end

  assign gnt_idx = r_idx;
  assign preempt = r_preempt;

  decoder_2_to_4 u_dec (
    .i_ena (w_dec_ena),
    .i_in  (r_idx),
    .o_out (gnt)
  );
endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1, ena1 = 1'b1;
  logic [3:0] req = 4'b0, req1 = 4'b0;
  logic [3:0] gnt, gnt1;
  logic [1:0] gnt_idx, gnt_idx1;
  logic       gnt_valid, gnt_valid1, preempt, preempt1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(8)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .preempt(preempt)
  );

  rr_arbiter_4 #(.MAX_HOLD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .req(req1),
    .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_valid(gnt_valid1), .preempt(preempt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0; ena = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Check a live grant on u0: one-hot, index and valid together.
  task automatic chk_gnt(input string tag, input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    chk({tag, ".gnt"}, gnt, oh);
    chk({tag, ".vld"}, gnt_valid, 1'b1);
    if (gnt_valid) chk({tag, ".idx"}, gnt_idx, idx);
  endtask

  task automatic chk_gap(input string tag, input logic pre);
    chk({tag, ".gnt"}, gnt, 4'b0);
    chk({tag, ".vld"}, gnt_valid, 1'b0);
    chk({tag, ".pre"}, preempt, pre);
  endtask

  initial begin
    logic [1:0] o;

    // ---- Reset and asynchronous drop ----
    tick(); tick();
    chk_gap("rst", 1'b0);
    chk("rst.gnt1", gnt1, 4'b0);
    chk("rst.pre1", preempt1, 1'b0);
    rst_n = 1'b1;
    req = 4'b0010;
    tick();
    chk_gnt("rst.g1", 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_gap("rst.async", 1'b0);
    #1 rst_n = 1'b1;
    req = 4'b1111;
    tick();
    chk_gnt("rst.first", 2'd0);

    // ---- Full rotation, 2-cycle grants, single gap cycle ----
    for (int k = 0; k < 5; k++) begin
      o = 2'(k % 4);
      chk_gnt($sformatf("rot%0d.c1", k), o);
      tick();
      chk_gnt($sformatf("rot%0d.c2", k), o);
      req[o] = 1'b0;
      tick();
      chk_gap($sformatf("rot%0d.gap", k), 1'b0);
      req[o] = 1'b1;
      tick();
    end
    chk_gnt("rot.next", 2'd1);
    req = 4'b0;
    tick(); tick();

    // ---- Forced release at MAX_HOLD=8 ----
    do_reset();
    req = 4'b0101;
    tick();
    for (int c = 0; c < 8; c++) begin
      chk_gnt($sformatf("hold0.%0d", c), 2'd0);
      chk("hold0.pre", preempt, 1'b0);
      tick();
    end
    chk_gap("hold0.gap", 1'b1);
    tick();
    for (int c = 0; c < 8; c++) begin
      chk_gnt($sformatf("hold2.%0d", c), 2'd2);
      chk("hold2.pre", preempt, 1'b0);
      tick();
    end
    chk_gap("hold2.gap", 1'b1);
    tick();
    chk_gnt("hold.back0", 2'd0);
    req = 4'b0;
    tick(); tick();

    // ---- Release coincident with hold limit: no preempt ----
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 0; c < 7; c++) tick();
    chk_gnt("relim.last", 2'd0);
    req = 4'b0;
    tick();
    chk_gap("relim.gap", 1'b0);
    tick();

    // ---- Skip and pointer wrap ----
    do_reset();
    req = 4'b0100;
    tick();
    chk_gnt("skip.g2", 2'd2);
    req = 4'b0;
    tick();
    chk_gap("skip.gap", 1'b0);
    req = 4'b1001;
    tick();
    chk_gnt("wrap.g3", 2'd3);
    req = 4'b0001;
    tick();
    chk_gap("wrap.gap", 1'b0);
    req = 4'b1011;
    tick();
    chk_gnt("wrap.g0", 2'd0);
    req = 4'b0;
    tick(); tick();

    // ---- ena control ----
    do_reset();
    ena = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_gap($sformatf("ena0.%0d", c), 1'b0);
    end
    req = 4'b0110;
    ena = 1'b1;
    tick();
    chk_gnt("abort.g1", 2'd1);
    ena = 1'b0;
    tick();
    chk_gap("abort.gap", 1'b0);
    tick();
    chk_gap("abort.idle", 1'b0);
    ena = 1'b1;
    tick();
    chk_gnt("abort.regrant", 2'd1);
    req = 4'b0;
    tick(); tick();

    // ---- Latency and unlimited hold (MAX_HOLD=0) ----
    req1 = 4'b0001;
    chk("lat.pre_edge", gnt1, 4'b0);
    tick();
    chk("lat.gnt1", gnt1, 4'b0001);
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("stream.gnt1", gnt1, 4'b0001);
      chk("stream.pre1", preempt1, 1'b0);
    end
    if (gnt_valid1) chk("stream.idx1", gnt_idx1, 2'd0);
    req1 = 4'b0;
    tick();
    chk("stream.rel", gnt1, 4'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
